bcd_serial_adder_ctrl: RTL and testbench

Sequencer that adds or subtracts two multi-digit packed-BCD operands by stepping a single-digit BCD adder cell (4-bit A, 4-bit B, cin → 4-bit sum, cout) over the digits, least-significant digit first. One digit is processed per cycle, and the digit carry is kept in a register between steps. The block sits between a valid/ready operand source and a valid/ready result sink. It is the multi-digit front end of the BCD arithmetic path.

---
 rtl/bcd_serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD add/subtract sequencer. It steps one BCD digit cell
// per cycle, least-significant digit first, between valid/ready handshakes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | in_ready high; waits for an operand bundle
// S_RUN  | one digit per cycle through the digit cell; busy high
// S_DONE | out_valid high; result/co/err held until out_ready
module bcd_serial_adder_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  sub,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   result,
   output logic                  co,
   output logic                  err,
   output logic                  busy
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [4*DIGITS-1:0] a_q, b_q, result_q;
   logic                sub_q, carry, co_q, err_q;
   logic [IW-1:0]       idx;

   logic       bad_digit;
   logic [3:0] a_dig, b_dig, b_eff, sum;
   logic [4:0] raw;
   logic       cout;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9))
            bad_digit = 1'b1;
      end
   end

   // Single BCD digit cell fed from the operand registers only
   always_comb begin
      a_dig = 4'd0;
      b_dig = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            a_dig = a_q[4*i +: 4];
            b_dig = b_q[4*i +: 4];
         end
      end
      b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
      raw   = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry};
      if (raw > 5'd9) begin
         sum  = raw[3:0] + 4'd6;
         cout = 1'b1;
      end else begin
         sum  = raw[3:0];
         cout = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry    <= 1'b0;
         idx      <= '0;
         result_q <= '0;
         co_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  sub_q    <= sub;
                  carry    <= sub ? ~cin : cin;
                  idx      <= '0;
                  result_q <= '0;
                  co_q     <= 1'b0;
                  err_q    <= bad_digit;
                  state    <= bad_digit ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx == IW'(i))
                     result_q[4*i +: 4] <= sum;
               end
               carry <= cout;
               if (idx == LAST) begin
                  idx   <= '0;
                  co_q  <= cout;
                  state <= S_DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state == S_RUN);
   assign out_valid = (state == S_DONE);
   assign result    = result_q;
   assign co        = co_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for bcd_serial_adder_ctrl (DIGITS=4): directed vectors push
// expected responses; a monitor checks latency, busy count and result on handoff.
module tb_bcd_serial_adder_ctrl;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0, b = '0;
   logic        sub = 1'b0, cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic        co, err, busy;

   bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .co(co), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] r;
      logic        co;
      logic        err;
      int          lat;
      int          bsy;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   t_acc = 0;
   int   bcnt = 0;
   logic ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: latency/busy on out_valid rise, payload on handoff
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            t_acc = cyc;
            bcnt  = 0;
         end else if (busy) begin
            bcnt++;
         end
         if (out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               chk("latency", cyc - t_acc, sb[0].lat);
               chk("busy_cycles", bcnt, sb[0].bsy);
            end
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            chk("result", {16'd0, result}, {16'd0, sb[0].r});
            chk("co", {31'd0, co}, {31'd0, sb[0].co});
            chk("err", {31'd0, err}, {31'd0, sb[0].err});
            void'(sb.pop_front());
         end
      end
      ov_prev = out_valid;
   end

   task automatic send(input logic [15:0] va, input logic [15:0] vb,
                       input logic vs, input logic vc, input logic push,
                       input logic [15:0] er, input logic eco, input logic eer,
                       output int acc);
      exp_t e;
      int   n;
      bit   done;
      a = va; b = vb; sub = vs; cin = vc; in_valid = 1'b1;
      if (push) begin
         e.r = er; e.co = eco; e.err = eer;
         e.lat = eer ? 1 : DIGITS + 1;
         e.bsy = eer ? 0 : DIGITS;
         sb.push_back(e);
      end
      n = 0; done = 1'b0; acc = -1;
      while (!done && n < 60) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            acc  = cyc;
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      a = 16'hFFFF; b = 16'hFFFF; sub = ~vs; cin = ~vc;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (!in_ready && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk(nm, 32'd0, 32'd1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_result"}, {16'd0, result}, 32'd0);
      chk({nm, "_co"}, {31'd0, co}, 32'd0);
      chk({nm, "_err"}, {31'd0, err}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc1, acc2, n;
      bit  seen;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;

      // a, b, sub, cin, push, expected result, co, err
      send(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, acc1);
      send(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, acc1);
      send(16'h9999, 16'h9999, 1'b0, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0, acc1);
      send(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0, acc1);
      send(16'h1234, 16'h5000, 1'b1, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0, acc1);
      send(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, acc1);
      send(16'h12A4, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, acc1);
      send(16'h0000, 16'h00F0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, acc1);

      // Second bundle arrives during RUN; must wait for IDLE
      wait_idle("idle_timeout_pair");
      send(16'h0458, 16'h0367, 1'b0, 1'b0, 1'b1, 16'h0825, 1'b0, 1'b0, acc1);
      send(16'h0100, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, acc2);
      chk("accept_spacing", acc2 - acc1, DIGITS + 2);

      // Back-pressure in DONE
      wait_idle("idle_timeout_bp");
      out_ready = 1'b0;
      send(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, acc1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_result", {16'd0, result}, 32'h6912);
         chk("hold_co", {31'd0, co}, 32'd0);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;

      // Reset mid-RUN: no output for the aborted operation
      wait_idle("idle_timeout_rst");
      send(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, acc1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_vals("midrun_reset");
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("no_out_valid_after_reset", {31'd0, seen}, 32'd0);
      send(16'h2718, 16'h3141, 1'b0, 1'b1, 1'b1, 16'h5860, 1'b0, 1'b0, acc1);

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
